// File: rtl/dec_gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready flow control and an
// optional step checker that flags illegal jumps in a decoded counter stream.
module dec_gray2bin_pipe #(
  parameter int WIDTH      = 10,
  parameter int STAGES     = 3,
  parameter bit CHECK_STEP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step_err,
  output logic             err_sticky,
  input  logic             clr_err
);

  localparam int B = (WIDTH + STAGES - 1) / STAGES;

  // Resolve the binary bits owned by stage s (0-based), MSB-first. Bits above
  // the slice come from the upstream stage and seed the XOR carry.
  function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] g,
                                                input logic [WIDTH-1:0] b,
                                                input int               s);
    logic [WIDTH-1:0] r;
    logic             c;
    int               hi;
    int               lo;
    r  = b;
    c  = 1'b0;
    hi = WIDTH - 1 - s * B;
    lo = WIDTH - (s + 1) * B;
    if (lo < 0) lo = 0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (j > hi) begin
        c = b[j];
      end else if (j >= lo) begin
        r[j] = c ^ g[j];
        c    = r[j];
      end
    end
    return r;
  endfunction

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_up;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  gray_q  [STAGES];
  logic [WIDTH-1:0]  gray_d  [STAGES];
  logic [WIDTH-1:0]  gray_up [STAGES];
  logic [WIDTH-1:0]  bin_q   [STAGES];
  logic [WIDTH-1:0]  bin_d   [STAGES];
  logic [WIDTH-1:0]  bin_up  [STAGES];

  // Ready chain unrolled from the output side so each term depends only on
  // registered valids and out_ready.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      acc    = !vld_q[s] || acc;
      rdy[s] = acc;
    end
  end

  always_comb begin
    vld_up     = '0;
    vld_up[0]  = in_valid;
    gray_up[0] = in_gray;
    bin_up[0]  = '0;
    for (int s = 1; s < STAGES; s++) begin
      vld_up[s]  = vld_q[s-1];
      gray_up[s] = gray_q[s-1];
      bin_up[s]  = bin_q[s-1];
    end
  end

  always_comb begin
    vld_d  = vld_q;
    gray_d = gray_q;
    bin_d  = bin_q;
    for (int s = 0; s < STAGES; s++) begin
      if (rdy[s]) vld_d[s] = vld_up[s];
      if (rdy[s] && vld_up[s]) begin
        gray_d[s] = gray_up[s];
        bin_d[s]  = resolve(gray_up[s], bin_up[s], s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        gray_q[s] <= '0;
        bin_q[s]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < STAGES; s++) begin
        gray_q[s] <= gray_d[s];
        bin_q[s]  <= bin_d[s];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_bin   = bin_q[STAGES-1];

  if (CHECK_STEP) begin : g_chk
    logic             hs;
    logic             step_err;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_bin_q;
    logic [WIDTH-1:0] prev_bin_d;
    logic             prev_vld_q;
    logic             prev_vld_d;
    logic             sticky_q;
    logic             sticky_d;

    assign hs = out_valid && out_ready;

    // A repeat or a +1 (with wrap) is a legal Gray-counter step.
    always_comb begin
      prev_inc   = prev_bin_q + 1'b1;
      step_err   = prev_vld_q && out_valid &&
                   (out_bin != prev_bin_q) && (out_bin != prev_inc);
      prev_bin_d = hs ? out_bin : prev_bin_q;
      prev_vld_d = prev_vld_q || hs;
      sticky_d   = sticky_q;
      if (clr_err)        sticky_d = 1'b0;
      if (hs && step_err) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_bin_q <= '0;
        prev_vld_q <= 1'b0;
        sticky_q   <= 1'b0;
      end else begin
        prev_bin_q <= prev_bin_d;
        prev_vld_q <= prev_vld_d;
        sticky_q   <= sticky_d;
      end
    end

    assign out_step_err = step_err;
    assign err_sticky   = sticky_q;
  end else begin : g_nochk
    assign out_step_err = 1'b0;
    assign err_sticky   = 1'b0;
  end

endmodule

// File: tb/tb_dec_gray2bin_pipe.sv
// Scoreboard bench for dec_gray2bin_pipe (WIDTH=10, STAGES=3, checker on).
module tb_dec_gray2bin_pipe;
  localparam int W = 10;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_gray;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
  logic         out_step_err;
  logic         err_sticky;
  logic         clr_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] sb_bin[$];
  logic         sb_err[$];
  logic [W-1:0] prev_b;
  logic         have_prev;
  logic         exp_sticky;

  logic         obs_vld, obs_rdy, obs_acc, obs_sticky;
  logic [W-1:0] obs_bin;

  dec_gray2bin_pipe #(.WIDTH(W), .STAGES(S), .CHECK_STEP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_step_err(out_step_err), .err_sticky(err_sticky), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int sh = 1; sh < W; sh++) b = b ^ (g >> sh);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock of stimulus; pops/compares outputs and pushes accepted inputs.
  task automatic drive_cycle(input logic v, input logic [W-1:0] g,
                             input logic ordy, input logic clr);
    logic [W-1:0] eb, b, nx;
    logic         ee, e, set_s;
    @(negedge clk);
    in_valid  = v;
    in_gray   = g;
    out_ready = ordy;
    clr_err   = clr;
    #1;
    obs_vld    = out_valid;
    obs_bin    = out_bin;
    obs_rdy    = in_ready;
    obs_sticky = err_sticky;
    set_s      = 1'b0;
    n_tests++;
    if (err_sticky !== exp_sticky) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required %b", err_sticky, exp_sticky);
    end
    if (out_valid && out_ready) begin
      n_tests++;
      if (sb_bin.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got out_bin=%h, required no output", out_bin);
      end else begin
        eb = sb_bin.pop_front();
        ee = sb_err.pop_front();
        if (out_bin !== eb) begin
          n_fail++;
          $display("FAIL out_bin: got %h, required %h", out_bin, eb);
        end
        n_tests++;
        if (out_step_err !== ee) begin
          n_fail++;
          $display("FAIL out_step_err: got %b, required %b (out_bin %h)", out_step_err, ee, eb);
        end
        set_s = ee;
      end
    end
    obs_acc = in_valid && in_ready;
    if (obs_acc) begin
      b  = g2b(in_gray);
      nx = prev_b + 1'b1;
      e  = have_prev && (b !== prev_b) && (b !== nx);
      sb_bin.push_back(b);
      sb_err.push_back(e);
      prev_b    = b;
      have_prev = 1'b1;
    end
    if (set_s)    exp_sticky = 1'b1;
    else if (clr) exp_sticky = 1'b0;
    @(posedge clk);
  endtask

  task automatic clear_model();
    sb_bin.delete();
    sb_err.delete();
    have_prev  = 1'b0;
    prev_b     = '0;
    exp_sticky = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_tests++;
    if (out_bin !== '0) begin n_fail++; $display("FAIL reset_out_bin: got %h, required 000", out_bin); end
    n_tests++;
    if (out_step_err !== 1'b0 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got step_err=%b sticky=%b, required 0 0", out_step_err, err_sticky);
    end
  endtask

  task automatic test_latency();
    do_reset();
    drive_cycle(1'b1, 10'h3FF, 1'b1, 1'b0);
    drive_cycle(1'b1, 10'h200, 1'b1, 1'b0);
    n_tests++;
    if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL latency_c1: got out_valid=%b, required 0", obs_vld); end
    drive_cycle(1'b1, 10'h001, 1'b1, 1'b0);
    n_tests++;
    if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL latency_c2: got out_valid=%b, required 0", obs_vld); end
    drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (obs_vld !== 1'b1 || obs_bin !== 10'h2AA) begin
      n_fail++;
      $display("FAIL latency_c3: got out_valid=%b out_bin=%h, required 1 2aa", obs_vld, obs_bin);
    end
    repeat (3) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (sb_bin.size() != 0) begin n_fail++; $display("FAIL latency_drain: got %0d pending, required 0", sb_bin.size()); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seq [5];
    seq = '{10'h000, 10'h001, 10'h003, 10'h002, 10'h006};
    do_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, seq[i], 1'b1, 1'b0);
    repeat (3) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (sb_bin.size() != 0) begin n_fail++; $display("FAIL b2b_throughput: got %0d pending, required 0", sb_bin.size()); end
    drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (obs_sticky !== 1'b0) begin n_fail++; $display("FAIL b2b_sticky: got %b, required 0", obs_sticky); end
  endtask

  task automatic test_step_err();
    do_reset();
    drive_cycle(1'b1, 10'h002, 1'b1, 1'b0);
    drive_cycle(1'b1, 10'h007, 1'b1, 1'b0);
    repeat (4) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (obs_sticky !== 1'b1) begin n_fail++; $display("FAIL step_sticky_set: got %b, required 1", obs_sticky); end
    drive_cycle(1'b0, 10'h000, 1'b1, 1'b1);
    drive_cycle(1'b1, 10'h007, 1'b1, 1'b0);
    n_tests++;
    if (obs_sticky !== 1'b0) begin n_fail++; $display("FAIL step_sticky_clr: got %b, required 0", obs_sticky); end
    repeat (4) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (sb_bin.size() != 0 || obs_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL step_repeat: got pending=%0d sticky=%b, required 0 0", sb_bin.size(), obs_sticky);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_cycle(1'b1, 10'h200, 1'b1, 1'b0);
    drive_cycle(1'b1, 10'h000, 1'b1, 1'b0);
    repeat (4) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (sb_bin.size() != 0 || obs_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: got pending=%0d sticky=%b, required 0 0", sb_bin.size(), obs_sticky);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words [5];
    logic [W-1:0] held;
    logic         have_held;
    int           idx;
    for (int i = 0; i < 5; i++) words[i] = b2g(W'(10 + i));
    idx = 0;
    have_held = 1'b0;
    held = '0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b1, words[idx], 1'b0, 1'b0);
      if (obs_acc && idx < 4) idx++;
      if (obs_vld) begin
        if (!have_held) begin
          held = obs_bin;
          have_held = 1'b1;
        end else begin
          n_tests++;
          if (obs_bin !== held) begin n_fail++; $display("FAIL bp_stable: got %h, required %h", obs_bin, held); end
        end
      end
    end
    n_tests++;
    if (idx != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 3", idx); end
    n_tests++;
    if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, required 0", obs_rdy); end
    n_tests++;
    if (held !== 10'd10) begin n_fail++; $display("FAIL bp_head: got %h, required 00a", held); end
    repeat (5) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (sb_bin.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, required 0", sb_bin.size()); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive_cycle(1'b1, 10'h002, 1'b1, 1'b0);
    drive_cycle(1'b1, 10'h007, 1'b1, 1'b0);
    repeat (4) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    drive_cycle(1'b1, b2g(10'd20), 1'b1, 1'b0);
    drive_cycle(1'b1, b2g(10'd21), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_gray = b2g(10'd30); out_ready = 1'b1; clr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    clear_model();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: got out_valid=%b in_ready=%b sticky=%b, required 0 1 0",
               out_valid, in_ready, err_sticky);
    end
    drive_cycle(1'b1, b2g(10'd40), 1'b1, 1'b0);
    repeat (5) drive_cycle(1'b0, 10'h000, 1'b1, 1'b0);
    n_tests++;
    if (sb_bin.size() != 0) begin n_fail++; $display("FAIL midrst_drain: got %0d pending, required 0", sb_bin.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_gray = '0; out_ready = 1'b0; clr_err = 1'b0;
    clear_model();
    obs_vld = 1'b0; obs_rdy = 1'b0; obs_acc = 1'b0; obs_sticky = 1'b0; obs_bin = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_step_err();
    test_wrap();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
